// File: rtl/wrr_sched_pkg.sv
// Shared types for the weighted round-robin grant scheduler: FSM states,
// the default weight type and a one-hot to index helper.
package wrr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT
    } state_e;

    localparam int WEIGHT_W = 4;

    typedef logic [WEIGHT_W-1:0] weight_t;

    // Index of the highest set bit; callers only ever pass one-hot or zero.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        onehot_to_idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                onehot_to_idx = 5'(i);
            end
        end
    endfunction

endpackage

// File: rtl/wrr_grant_scheduler_rr_pick.sv
// Combinational round-robin pick: first eligible requester at or after ptr,
// wrapping, returned as one-hot, index and a found flag.
module wrr_grant_scheduler_rr_pick
    import wrr_sched_pkg::*;
#(
    parameter int NREQ = 16,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            found
);

    int j;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        onehot = '0;
        found  = 1'b0;
        j      = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && eligible[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
            end
        end
    end

    assign idx = IW'(onehot_to_idx(32'(onehot)));

endmodule

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin scheduler granting one shared resource per packet.
// Optional forced release of a stalled grant: define WRR_TIMEOUT_EN.
module wrr_grant_scheduler
    import wrr_sched_pkg::*;
#(
    parameter int NREQ         = 16,
    parameter int WW           = WEIGHT_W,
    parameter int DEF_WEIGHT   = 1,
    parameter int HOLD_TIMEOUT = 64,
    localparam int IW          = $clog2(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_last,
    input  logic            res_ready,
    input  logic            cfg_wr,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [WW-1:0]   cfg_weight,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_id,
    output logic            busy,
    output logic            timeout_evt
);

    state_e          state, state_nxt;
    logic [WW-1:0]   weight [NREQ];
    logic [WW-1:0]   credit;
    logic            in_pkt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   next_ptr;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;

    logic            in_grant;
    logic            beat;
    logic            pkt_end;
    logic            wind_down;
    logic            release_now;
    logic            timeout_hit;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] & (weight[i] != '0);
        end
    end

    wrr_grant_scheduler_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .onehot   (pick_oh),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    assign in_grant  = (state == GRANT);
    assign beat      = in_grant & req_valid[grant_id] & res_ready;
    assign pkt_end   = beat & req_last[grant_id];
    // Disable or a zero weight lets the current packet finish but never starts a new one.
    assign wind_down = !enable | (weight[grant_id] == '0);

    assign release_now = in_grant & (
                           (pkt_end & (credit == WW'(1)))
                         | (!in_pkt & !req_valid[grant_id])
                         | (wind_down & (pkt_end | (!in_pkt & !beat)))
                         | timeout_hit);

    assign next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
    assign busy     = in_grant;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable && (|eligible)) state_nxt = ARB;
            ARB:     state_nxt = (enable && pick_found) ? GRANT : IDLE;
            GRANT:   if (release_now) state_nxt = enable ? ARB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            credit   <= '0;
            in_pkt   <= 1'b0;
            ptr      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            if (state == ARB && state_nxt == GRANT) begin
                grant    <= pick_oh;
                grant_id <= pick_idx;
                credit   <= weight[pick_idx];
                in_pkt   <= 1'b0;
            end else if (in_grant) begin
                if (release_now) begin
                    grant    <= '0;
                    grant_id <= '0;
                    credit   <= '0;
                    in_pkt   <= 1'b0;
                    ptr      <= next_ptr;
                end else if (pkt_end) begin
                    credit <= credit - WW'(1);
                    in_pkt <= 1'b0;
                end else if (beat) begin
                    in_pkt <= 1'b1;
                end
            end
        end
    end

    // Weight writes land in the table only; credit picks them up at the next load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the weight table is reset because DEF_WEIGHT is visible architectural state.
            for (int i = 0; i < NREQ; i++) begin
                weight[i] <= WW'(DEF_WEIGHT);
            end
        end else if (cfg_wr && (int'(cfg_idx) < NREQ)) begin
            weight[cfg_idx] <= cfg_weight;
        end
    end

`ifdef WRR_TIMEOUT_EN
    localparam int TW = $clog2(HOLD_TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;

    assign timeout_hit = in_grant & !beat & (idle_cnt == TW'(HOLD_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= timeout_hit;
            if (!in_grant || beat || release_now) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// Directed self-checking bench for wrr_grant_scheduler; expected values are
// hand-derived cycle by cycle from a known pointer and weight history.
module tb_wrr_grant_scheduler;

    localparam int NREQ = 16;
    localparam int WW   = 4;
    localparam int IW   = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_last;
    logic            res_ready;
    logic            cfg_wr;
    logic [IW-1:0]   cfg_idx;
    logic [WW-1:0]   cfg_weight;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            timeout_evt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_t2 [6] = '{16'h0008, 16'h0008, 16'h0008, 16'h0000, 16'h0020, 16'h0000};

    wrr_grant_scheduler #(
        .NREQ         (NREQ),
        .WW           (WW),
        .DEF_WEIGHT   (1),
        .HOLD_TIMEOUT (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .res_ready   (res_ready),
        .cfg_wr      (cfg_wr),
        .cfg_idx     (cfg_idx),
        .cfg_weight  (cfg_weight),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic write_weight(input logic [IW-1:0] idx, input logic [WW-1:0] w);
        cfg_wr     = 1'b1;
        cfg_idx    = idx;
        cfg_weight = w;
        cyc();
        cfg_wr     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        res_ready  = 1'b0;
        cfg_wr     = 1'b0;
        cfg_idx    = '0;
        cfg_weight = '0;
        cyc(3);
        check("rst_grant", 32'(grant), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_evt", 32'(timeout_evt), 0);
        reset = 1'b1;
        cyc();

        // Test 1: all weights 1, everyone requesting single-beat packets.
        enable    = 1'b1;
        res_ready = 1'b1;
        req_last  = '1;
        req_valid = '1;
        cyc();
        check("t1_latency", 32'(grant), 0);
        for (int m = 0; m <= 16; m++) begin
            cyc();
            check($sformatf("t1_grant%0d", m), 32'(grant), 32'(1 << (m % 16)));
            check($sformatf("t1_id%0d", m), 32'(grant_id), 32'(m % 16));
            cyc();
            check($sformatf("t1_gap%0d", m), 32'(grant), 0);
        end
        req_valid = '0;
        cyc(2);
        check("t1_idle_busy", 32'(busy), 0);

        // Test 2: weight[3]=3, req 3 and 5 only; pointer starts at 1.
        write_weight(4'd3, 4'd3);
        req_valid = 16'h0028;
        cyc();
        check("t2_latency", 32'(grant), 0);
        for (int r = 0; r < 12; r++) begin
            cyc();
            check($sformatf("t2_step%0d", r), 32'(grant), 32'(exp_t2[r % 6]));
        end
        req_valid = '0;
        cyc(2);

        // Test 3: 4-beat packet on req 2 with a 2-cycle res_ready stall.
        req_last  = '0;
        req_valid = 16'h0004;
        cyc(2);
        check("t3_grant", 32'(grant), 32'h4);
        cyc();
        check("t3_beat1", 32'(grant), 32'h4);
        res_ready = 1'b0;
        cyc();
        check("t3_stall1", 32'(grant), 32'h4);
        cyc();
        check("t3_stall2", 32'(grant), 32'h4);
        res_ready = 1'b1;
        cyc();
        check("t3_beat2", 32'(grant), 32'h4);
        cyc();
        check("t3_beat3", 32'(grant), 32'h4);
        req_last = 16'h0004;
        cyc();
        check("t3_release", 32'(grant), 0);
        req_valid = '0;
        req_last  = '0;
        cyc(2);

        // Test 4: req 3 (weight 3) loses enable on beat 2 of a 4-beat packet.
        req_valid = 16'h0008;
        cyc(2);
        check("t4_grant", 32'(grant), 32'h8);
        check("t4_busy", 32'(busy), 1);
        cyc();
        check("t4_beat1", 32'(grant), 32'h8);
        enable = 1'b0;
        cyc();
        check("t4_beat2_held", 32'(grant), 32'h8);
        cyc();
        check("t4_beat3_held", 32'(grant), 32'h8);
        req_last = 16'h0008;
        cyc();
        check("t4_release_grant", 32'(grant), 0);
        check("t4_release_busy", 32'(busy), 0);
        check("t4_release_id", 32'(grant_id), 0);
        cyc(2);
        check("t4_stay_idle_grant", 32'(grant), 0);
        check("t4_stay_idle_busy", 32'(busy), 0);
        req_valid = '0;
        req_last  = '0;
        enable    = 1'b1;
        cyc();

        // Test 5: zero weight blocks req 7 until the weight is rewritten.
        write_weight(4'd7, 4'd0);
        req_valid = 16'h0080;
        req_last  = '1;
        cyc(6);
        check("t5_blocked_grant", 32'(grant), 0);
        check("t5_blocked_busy", 32'(busy), 0);
        cfg_wr     = 1'b1;
        cfg_idx    = 4'd7;
        cfg_weight = 4'd2;
        cyc();
        cfg_wr = 1'b0;
        check("t5_wr_edge", 32'(grant), 0);
        cyc();
        check("t5_arb", 32'(grant), 0);
        cyc();
        check("t5_grant", 32'(grant), 32'h80);
        check("t5_grant_id", 32'(grant_id), 7);
        cyc();
        check("t5_second_pkt", 32'(grant), 32'h80);
        cyc();
        check("t5_release", 32'(grant), 0);
        req_valid = '0;
        cyc(2);

        // Test 6: req 9 stalls mid-packet while req 10 waits.
        req_valid = 16'h0600;
        req_last  = 16'h0400;
        res_ready = 1'b1;
        cyc(2);
        check("t6_grant", 32'(grant), 32'h200);
        cyc();
        check("t6_beat1", 32'(grant), 32'h200);
        res_ready = 1'b0;
        cyc(7);
        check("t6_stall7_grant", 32'(grant), 32'h200);
        check("t6_stall7_evt", 32'(timeout_evt), 0);
`ifdef WRR_TIMEOUT_EN
        cyc();
        check("t6_forced_release", 32'(grant), 0);
        check("t6_evt_pulse", 32'(timeout_evt), 1);
        cyc();
        check("t6_next_grant", 32'(grant), 32'h400);
        check("t6_evt_clear", 32'(timeout_evt), 0);
`else
        cyc();
        check("t6_held_grant", 32'(grant), 32'h200);
        check("t6_no_evt", 32'(timeout_evt), 0);
        cyc(10);
        check("t6_held_long", 32'(grant), 32'h200);
        check("t6_held_busy", 32'(busy), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
